// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master: bus widths, FSM state
// encoding, quarter-phase encoding and the SCL level decode helper.
// No ports; imported by i2c_clk_gen and i2c_master_controller.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_WR_DATA  = 4'd4,
    ST_WR_ACK   = 4'd5,
    ST_RD_DATA  = 4'd6,
    ST_RD_NACK  = 4'd7,
    ST_STOP     = 4'd8
  } state_t;

  // Quarters of one bit slot: Q0/Q1 SCL low, Q2/Q3 SCL high.
  typedef enum logic [1:0] {
    PH_Q0 = 2'd0,
    PH_Q1 = 2'd1,
    PH_Q2 = 2'd2,
    PH_Q3 = 2'd3
  } phase_t;

  // SCL stays high while idle and through the START slot; every other slot
  // (including STOP) is low for the first half and high for the second.
  function automatic logic scl_level(input state_t st, input phase_t ph);
    logic lvl;
    case (st)
      ST_IDLE, ST_START: lvl = 1'b1;
      default:           lvl = ph[1];
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period timebase: strobes tick_o every CLK_DIV clocks and steps phase_o Q0..Q3.
// Latency: tick_o combinational from the counter; phase_o advances on the clock after a tick.
// Backpressure: none; held at zero while en_i is low so every transaction starts at Q0.
// Ports: clk/rst_n (async active-low), en_i run enable, tick_o quarter strobe, phase_o current quarter.
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  output logic   tick_o,
  output phase_t phase_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  phase_t        phase_q, phase_d;

  assign tick_o  = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign phase_o = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = PH_Q0;
    end else if (tick_o) begin
      cnt_d   = '0;
      phase_d = phase_t'(phase_q + 2'd1);
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= PH_Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte (write, or read with NACK), STOP.
// Latency: 80*CLK_DIV clocks accept-to-done for a full transfer, 44*CLK_DIV on address NACK.
// Backpressure: a request is taken only while busy is low; enable during a transfer is dropped.
// Ports: clk, rst_n (async active-low), enable/addr/rw/data_in request, data_out read byte,
//        busy, done (1-cycle pulse), ack_err, scl (push-pull), sda (open-drain, 0 or Z).
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [I2C_ADDR_W-1:0] addr,
  input  logic                  rw,
  input  logic [I2C_DATA_W-1:0] data_in,
  output logic [I2C_DATA_W-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_err,
  output logic                  scl,
  inout  wire                   sda
);

  state_t                  state_q, state_d;
  logic [2:0]              bit_q, bit_d;
  logic [I2C_ADDR_W-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [I2C_DATA_W-1:0]   wdata_q, wdata_d;
  logic [I2C_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    nack_q, nack_d;
  logic                    ack_err_q, ack_err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    scl_q, scl_d;
  logic                    sda_low_q, sda_low_d;

  logic                    tick;
  phase_t                  phase;
  logic                    sample;
  logic                    slot_end;
  logic                    sda_in;
  logic [I2C_DATA_W-1:0]   frame;

  i2c_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (busy_q),
    .tick_o  (tick),
    .phase_o (phase)
  );

  // Bus sampling happens on the tick that enters Q3; slot changes on the tick leaving Q3.
  assign sample   = tick && (phase == PH_Q2);
  assign slot_end = tick && (phase == PH_Q3);
  assign sda_in   = sda;
  assign frame    = {addr_q, rw_q};

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    ack_err_d = ack_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sda_low_d = 1'b0;
    // Pin levels are decoded from the current state/phase and registered, so
    // SCL and SDA both lag the FSM by exactly one clock and stay mutually aligned.
    scl_d     = scl_level(state_q, phase);

    case (state_q)
      ST_IDLE: begin
        if (enable && !busy_q) begin
          addr_d    = addr;
          rw_d      = rw;
          wdata_d   = data_in;
          nack_d    = 1'b0;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        sda_low_d = phase[1];
        if (slot_end) begin
          bit_d   = 3'd7;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        sda_low_d = ~frame[bit_q];
        if (slot_end) begin
          if (bit_q == 3'd0) state_d = ST_ADDR_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end

      ST_ADDR_ACK: begin
        if (sample && sda_in) nack_d = 1'b1;
        if (slot_end) begin
          bit_d = 3'd7;
          if (nack_q)    state_d = ST_STOP;
          else if (rw_q) state_d = ST_RD_DATA;
          else           state_d = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        sda_low_d = ~wdata_q[bit_q];
        if (slot_end) begin
          if (bit_q == 3'd0) state_d = ST_WR_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end

      ST_WR_ACK: begin
        if (sample && sda_in) nack_d = 1'b1;
        if (slot_end) state_d = ST_STOP;
      end

      ST_RD_DATA: begin
        if (sample) rdata_d = {rdata_q[I2C_DATA_W-2:0], sda_in};
        if (slot_end) begin
          if (bit_q == 3'd0) state_d = ST_RD_NACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end

      ST_RD_NACK: begin
        if (slot_end) state_d = ST_STOP;
      end

      ST_STOP: begin
        // SDA low until Q3, so its release is the rising edge under high SCL.
        sda_low_d = (phase != PH_Q3);
        if (slot_end) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          ack_err_d = nack_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_q     <= 3'd0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign sda      = sda_low_q ? 1'b0 : 1'bz;
  assign scl      = scl_q;
  assign data_out = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;

endmodule
